sequential_divider9x4: RTL and testbench

//  Multi-cycle unsigned restoring divider; the inverse of the 5x4 array multiplier.

---
 rtl/sequential_divider9x4.sv | 117 +++++++++++
 tb/tb_sequential_divider9x4.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/sequential_divider9x4.sv
// Multi-cycle unsigned restoring divider: N-bit dividend / M-bit divisor,
// one quotient bit per clock, start/busy/done handshake.
module sequential_divider9x4 #(
  parameter int unsigned N = 9,
  parameter int unsigned M = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [M-1:0] remainder,
  output logic         dbz
);

  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           load, step, finish;
  logic [CW-1:0]  count_q;
  logic [N-1:0]   dq_q;     // dividend bits shift out of the top, quotient bits shift in at the bottom
  logic [M-1:0]   dv_q;
  logic [M-1:0]   rem_q;    // restored partial remainder is always < divisor, so M bits suffice
  logic [M:0]     r_sh;
  logic           qbit;
  logic [M-1:0]   r_next;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and control strobes
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = (divisor == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        step = 1'b1;
        if (count_q == CW'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        finish  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Restoring step: shift in next dividend bit, subtract divisor if it fits
  always_comb begin
    r_sh   = {rem_q, dq_q[N-1]};
    qbit   = (r_sh >= {1'b0, dv_q});
    r_next = qbit ? M'(r_sh - {1'b0, dv_q}) : r_sh[M-1:0];
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      dbz       <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      count_q   <= '0;
      dq_q      <= '0;
      dv_q      <= '0;
      rem_q     <= '0;
    end else begin
      busy <= (state_d != S_IDLE);
      done <= finish;
      if (load) begin
        dq_q      <= dividend;
        dv_q      <= divisor;
        rem_q     <= '0;
        count_q   <= (divisor == '0) ? '0 : CW'(N);
        quotient  <= '0;
        remainder <= '0;
        dbz       <= 1'b0;
      end else if (step) begin
        rem_q   <= r_next;
        dq_q    <= {dq_q[N-2:0], qbit};
        count_q <= count_q - CW'(1);
      end
      if (finish) begin
        if (dv_q == '0) begin
          quotient  <= '1;
          remainder <= '0;
          dbz       <= 1'b1;
        end else begin
          quotient  <= dq_q;
          remainder <= rem_q;
          dbz       <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sequential_divider9x4.sv
// Directed plus randomized checks of sequential_divider9x4 against plain
// integer division.
module tb_sequential_divider9x4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [8:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [8:0] quotient;
  logic [3:0] remainder;
  logic       dbz;

  int total = 0;
  int bad   = 0;

  sequential_divider9x4 dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called 1 time unit after a rising edge; start is sampled at the next edge
  task automatic start_op(input int a, input int b);
    dividend = 9'(a);
    divisor  = 4'(b);
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  // Counts edges since acceptance until done, bounded
  task automatic wait_done(input int n0, output int n, output bit busy_ok);
    n       = n0;
    busy_ok = 1'b1;
    while (done !== 1'b1 && n < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_check(input int a, input int b, input string tag);
    int n;
    bit bz;
    int eq, er, ez, el;
    if (b == 0) begin
      eq = 511; er = 0; ez = 1; el = 1;
    end else begin
      eq = a / b; er = a % b; ez = 0; el = 10;
    end
    start_op(a, b);
    chk({tag, "_busy_acc"}, 32'(busy), 1);
    chk({tag, "_q_clr"}, 32'(quotient), 0);
    wait_done(0, n, bz);
    chk({tag, "_lat"}, 32'(n), 32'(el));
    chk({tag, "_busy_run"}, 32'(bz), 1);
    chk({tag, "_q"}, 32'(quotient), 32'(eq));
    chk({tag, "_r"}, 32'(remainder), 32'(er));
    chk({tag, "_dbz"}, 32'(dbz), 32'(ez));
    chk({tag, "_busy_done"}, 32'(busy), 0);
  endtask

  initial begin
    int n;
    bit bz;
    int ra, rb;

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_q", 32'(quotient), 0);
    chk("rst_r", 32'(remainder), 0);
    chk("rst_dbz", 32'(dbz), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic and boundary divides
    run_check(200, 7, "t1");
    run_check(511, 15, "t2a");
    run_check(5, 9, "t2b");
    run_check(9, 0, "t3");
    repeat (3) begin @(posedge clk); #1; end
    chk("t3_hold_q", 32'(quotient), 511);
    chk("t3_hold_dbz", 32'(dbz), 1);
    chk("t3_hold_done", 32'(done), 0);

    // Start while running is ignored
    start_op(200, 7);
    repeat (3) begin @(posedge clk); #1; end
    dividend = 9'd100; divisor = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(4, n, bz);
    chk("t4_lat", 32'(n), 10);
    chk("t4_busy_run", 32'(bz), 1);
    chk("t4_q", 32'(quotient), 28);
    chk("t4_r", 32'(remainder), 4);

    // Start sampled on the DONE->IDLE edge is not accepted
    @(posedge clk); #1;
    start_op(77, 6);
    repeat (9) begin @(posedge clk); #1; end
    dividend = 9'd100; divisor = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t4b_done", 32'(done), 1);
    chk("t4b_q", 32'(quotient), 12);
    chk("t4b_r", 32'(remainder), 5);
    repeat (3) begin @(posedge clk); #1; end
    chk("t4b_idle_busy", 32'(busy), 0);
    chk("t4b_hold_q", 32'(quotient), 12);
    chk("t4b_hold_r", 32'(remainder), 5);

    // Asynchronous reset mid-run
    start_op(200, 7);
    repeat (5) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_done", 32'(done), 0);
    chk("t5_q", 32'(quotient), 0);
    chk("t5_r", 32'(remainder), 0);
    @(posedge clk); #1;
    chk("t5_no_done", 32'(done), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_check(77, 6, "t5_next");

    // Randomized operands, including zero divisors
    for (int i = 0; i < 40; i++) begin
      ra = int'($urandom_range(0, 511));
      rb = int'($urandom_range(0, 15));
      run_check(ra, rb, "rnd");
    end

    // Exhaustive product inverse, back-to-back starts
    for (int a = 0; a < 32; a++) begin
      for (int b = 1; b < 16; b++) begin
        run_check(a * b, b, "inv");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
